// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO unit driving the HI/LO write port.
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             hi_we,
  output logic [WIDTH-1:0] hi_data,
  output logic             lo_we,
  output logic [WIDTH-1:0] lo_data
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, m_q, m_d;
  logic div_q, div_d, sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
  logic hi_we_q, hi_we_d, lo_we_q, lo_we_d;
  logic [WIDTH-1:0] hi_data_q, hi_data_d, lo_data_q, lo_data_d;
  logic [WIDTH:0] sum, rem_sh;
  logic ge, na, nb;
  logic [WIDTH-1:0] mh, ml, dh, dl, nh, nl, abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  // acc holds product-high / partial remainder; sh holds multiplier / dividend-then-quotient
  assign sum    = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
  assign mh     = sum[WIDTH:1];
  assign ml     = {sum[0], sh_q[WIDTH-1:1]};
  assign rem_sh = {acc_q, sh_q[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, m_q};
  assign dh     = ge ? rem_sh[WIDTH-1:0] - m_q : rem_sh[WIDTH-1:0];
  assign dl     = {sh_q[WIDTH-2:0], ge};
  assign nh     = div_q ? dh : mh;
  assign nl     = div_q ? dl : ml;
  assign prod_fix = sq_q ? -{nh, nl} : {nh, nl};
  assign na     = ~op[0] & src_a[WIDTH-1];
  assign nb     = ~op[0] & src_b[WIDTH-1];
  assign abs_a  = na ? -src_a : src_a;
  assign abs_b  = nb ? -src_b : src_b;
  assign stall_req = (state_q == IDLE & start & ~op[2] & ~flush) | (state_q == CALC);
  assign hi_we   = hi_we_q & ~(flush & state_q == WB);
  assign lo_we   = lo_we_q & ~(flush & state_q == WB);
  assign hi_data = hi_data_q;
  assign lo_data = lo_data_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    sh_d = sh_q;
    m_d = m_q;
    div_d = div_q;
    sq_d = sq_q;
    sr_d = sr_q;
    dz_d = dz_q;
    hi_we_d = 1'b0;
    lo_we_d = 1'b0;
    hi_data_d = hi_data_q;
    lo_data_d = lo_data_q;
    case (state_q)
      IDLE: if (start && !flush) begin
        if (!op[2]) begin
          state_d = CALC;
          cnt_d = '0;
          acc_d = '0;
          div_d = op[1];
          sh_d = op[1] ? abs_a : abs_b;
          m_d = op[1] ? abs_b : abs_a;
          sq_d = na ^ nb;
          sr_d = na;
          dz_d = op[1] & (src_b == '0);
        end else if (op == 3'd4) begin
          hi_we_d = 1'b1;
          hi_data_d = src_a;
        end else if (op == 3'd5) begin
          lo_we_d = 1'b1;
          lo_data_d = src_a;
        end
      end
      CALC: if (flush) state_d = IDLE;
      else begin
        acc_d = nh;
        sh_d = nl;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = WB;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          hi_data_d = div_q ? (sr_q ? -nh : nh) : prod_fix[2*WIDTH-1:WIDTH];
          lo_data_d = div_q ? (dz_q ? '1 : sq_q ? -nl : nl) : prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      sh_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      dz_q <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      hi_data_q <= '0;
      lo_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sh_q <= sh_d;
      m_q <= m_d;
      div_q <= div_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      dz_q <= dz_d;
      hi_we_q <= hi_we_d;
      lo_we_q <= lo_we_d;
      hi_data_q <= hi_data_d;
      lo_data_q <= lo_data_d;
    end
  end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: vector table, randomized ops against an arithmetic model, and flush/reset sequences.
module tb_hilo_mdu;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic stall_req, hi_we, lo_we;
  logic [31:0] hi_data, lo_data;
  int pass_cnt = 0, total_cnt = 0;
  hilo_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall_req(stall_req), .hi_we(hi_we), .hi_data(hi_data),
    .lo_we(lo_we), .lo_data(lo_data)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b;
    logic [63:0] res;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask
  // {hi, lo} expected from plain signed/unsigned 64-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2, 3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd3) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: return {a, 32'h0};
      3'd5: return {32'h0, a};
      default: return 64'h0;
    endcase
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    int cyc, stl;
    logic got;
    cyc = 0;
    stl = 0;
    got = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 chk("stall_at_issue", stall_req, o <= 3);
    while (!got && cyc < (o > 5 ? 3 : 40)) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      got = hi_we | lo_we;
      if (!got && stall_req) stl++;
    end
    if (o > 5) begin
      chk("noop_write", got, 0);
      return;
    end
    chk("latency", cyc, o <= 3 ? 33 : 1);
    chk("stall_cycles", stl, o <= 3 ? 32 : 0);
    chk("stall_in_wb", stall_req, 0);
    chk("hi_we", hi_we, o != 5);
    chk("lo_we", lo_we, o != 4);
    if (o != 5) chk("hi_data", hi_data, e[63:32]);
    if (o != 4) chk("lo_data", lo_data, e[31:0]);
    @(posedge clk); #1;
    chk("we_pulse", {hi_we, lo_we}, 0);
  endtask
  initial begin
    int w;
    logic [2:0] o;
    logic [31:0] a, b;
    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h7,         64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3]  = '{3'd3, 32'd100,       32'd7,         64'h0000_0002_0000_000E};
    vecs[4]  = '{3'd3, 32'h5,         32'h0,         64'h0000_0005_FFFF_FFFF};
    vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[6]  = '{3'd2, 32'hFFFF_FFFB, 32'h0,         64'hFFFF_FFFB_FFFF_FFFF};
    vecs[7]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[8]  = '{3'd0, 32'h8000_0000, 32'h1,         64'hFFFF_FFFF_8000_0000};
    vecs[9]  = '{3'd2, 32'h7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    vecs[10] = '{3'd4, 32'h1234,      32'h0,         64'h0000_1234_0000_0000};
    vecs[11] = '{3'd5, 32'h5678,      32'h0,         64'h0000_0000_0000_5678};
    vecs[12] = '{3'd6, 32'hDEAD,      32'hBEEF,      64'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {stall_req, hi_we, lo_we, hi_data, lo_data}, 0);
    rst = 1'b0;
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      run_op(o, a, b, model(o, a, b));
    end
    // flush during CALC cancels the write; the unit accepts a new op right after
    w = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; src_a = 32'h1234_5678; src_b = 32'h9;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (hi_we | lo_we) w++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_stall_low", stall_req, 0);
    chk("flush_no_write", w + int'(hi_we) + int'(lo_we), 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    // flush in IDLE beats a same-cycle start, including MTHI
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; src_a = 32'hCAFE; flush = 1'b1;
    #1 chk("flush_idle_stall", stall_req, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_no_write", {hi_we, lo_we, stall_req}, 0);
    // reset mid-DIV drops the op and clears outputs
    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_div_outputs", {stall_req, hi_we, lo_we, hi_data, lo_data}, 0);
    w = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (hi_we | lo_we | stall_req) w++;
    end
    chk("rst_mid_div_quiet", w, 0);
    run_op(3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
